// File: rtl/sort_pkg.sv
// Shared definitions for the max-sort datapath and its streaming adapter.
package sort_pkg;

    // Sorter geometry and pipeline depth.
    localparam int M        = 8;
    localparam int N        = 8;
    localparam int W        = 4;
    localparam int SORT_LAT = 3;

    // Counter width helper: $clog2 with a one-bit floor so that single-entry
    // counters still have a real bit to hold.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    localparam int CNT_W = clog2_min1(M);
    localparam int IDX_W = clog2_min1(W);

    // Adapter control states.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } stream_state_t;

    // Parallel vectors exchanged with the sorter wrapper.
    typedef logic [M-1:0][N-1:0] lane_vec_t;
    typedef logic [W-1:0][N-1:0] res_vec_t;

endpackage

// File: rtl/sort_stream_drain.sv
// Result register and serialiser: holds the W sorted lanes captured from the
// sorter and hands them out one per valid/ready handshake, lane 0 first.
module sort_stream_drain
    import sort_pkg::*;
#(
    parameter int N = sort_pkg::N,
    parameter int W = sort_pkg::W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_capture,
    input  logic                i_active,
    input  logic [W-1:0][N-1:0] i_y_q,
    input  logic                i_m_ready,
    output logic [N-1:0]        o_m_data,
    output logic                o_m_last,
    output logic                o_done
);

    localparam int                   L_IDX_W  = clog2_min1(W);
    localparam logic [L_IDX_W-1:0]   IDX_LAST = L_IDX_W'(W - 1);

    logic [W-1:0][N-1:0] w_res;
    logic [L_IDX_W-1:0]  r_idx;
    logic                w_hs;
    logic                w_at_last;

    assign w_hs      = i_active && i_m_ready;
    assign w_at_last = (r_idx == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_res
            logic [N-1:0] r_lane;

            // Snapshot one sorted lane when the sorter latency has elapsed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane <= '0;
                end else if (i_capture) begin
                    r_lane <= i_y_q[gi];
                end
            end

            assign w_res[gi] = r_lane;
        end
    endgenerate

    // Output index: restart on capture, advance on every accepted element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_capture) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= w_at_last ? '0 : (r_idx + 1'b1);
        end
    end

    // Data comes straight from the result registers, so it holds while stalled.
    assign o_m_data = w_res[r_idx];
    assign o_m_last = i_active && w_at_last;
    assign o_done   = w_hs && w_at_last;

endmodule

// File: rtl/sort_stream_adapter.sv
// Serial-to-parallel front end and parallel-to-serial back end for the max
// sorter: packs up to M elements into o_chi, waits LAT cycles, then streams
// the W sorted results out through sort_stream_drain.
module sort_stream_adapter
    import sort_pkg::*;
#(
    parameter int          M   = sort_pkg::M,
    parameter int          N   = sort_pkg::N,
    parameter int          W   = sort_pkg::W,
    parameter int          LAT = sort_pkg::SORT_LAT,
    parameter logic [N-1:0] PAD = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [N-1:0]        s_data,
    input  logic                s_last,
    output logic [M-1:0][N-1:0] o_chi,
    input  logic [W-1:0][N-1:0] i_y_q,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [N-1:0]        m_data,
    output logic                m_last,
    output logic                o_busy
);

    localparam int                   L_CNT_W  = clog2_min1(M);
    localparam int                   L_LAT_W  = $clog2(LAT + 1);
    localparam logic [L_CNT_W-1:0]   CNT_LAST = L_CNT_W'(M - 1);
    localparam logic [L_LAT_W-1:0]   LAT_LAST = L_LAT_W'(LAT - 1);

    stream_state_t       r_state;
    stream_state_t       w_state_next;
    logic [L_CNT_W-1:0]  r_cnt;
    logic [L_LAT_W-1:0]  r_lat;
    logic [M-1:0][N-1:0] w_chi;

    logic w_in_fill;
    logic w_in_wait;
    logic w_in_drain;
    logic w_s_hs;
    logic w_fill_exit;
    logic w_lat_done;
    logic w_drain_done;

    assign w_in_fill   = (r_state == FILL);
    assign w_in_wait   = (r_state == WAIT);
    assign w_in_drain  = (r_state == DRAIN);

    // A frame closes on s_last or when the last lane is filled; both together
    // are still one exit.
    assign w_s_hs      = s_valid && w_in_fill;
    assign w_fill_exit = w_s_hs && (s_last || (r_cnt == CNT_LAST));
    assign w_lat_done  = w_in_wait && (r_lat == LAT_LAST);

    // Handshake flags depend on state alone, never on i_y_q or the inputs.
    assign s_ready = w_in_fill;
    assign m_valid = w_in_drain;
    assign o_busy  = !w_in_fill;
    assign o_chi   = w_chi;

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: FILL -> WAIT -> DRAIN -> FILL.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_fill_exit)  w_state_next = WAIT;
            WAIT:    if (w_lat_done)   w_state_next = DRAIN;
            DRAIN:   if (w_drain_done) w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // Fill count selects the lane for the next accepted element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_fill_exit) begin
            r_cnt <= '0;
        end else if (w_s_hs) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Latency count runs only in WAIT and is idle at zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat <= '0;
        end else if (w_in_wait && !w_lat_done) begin
            r_lat <= r_lat + 1'b1;
        end else begin
            r_lat <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_lane
            localparam logic [L_CNT_W-1:0] LANE = L_CNT_W'(gi);
            logic [N-1:0] r_lane;

            // Load this lane with its element, or pad it when the frame closes
            // before reaching it; held unchanged through WAIT and DRAIN.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane <= '0;
                end else if (w_s_hs) begin
                    if (r_cnt == LANE) begin
                        r_lane <= s_data;
                    end else if (w_fill_exit && (LANE > r_cnt)) begin
                        r_lane <= PAD;
                    end
                end
            end

            assign w_chi[gi] = r_lane;
        end
    endgenerate

    sort_stream_drain #(
        .N (N),
        .W (W)
    ) u_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_lat_done),
        .i_active  (w_in_drain),
        .i_y_q     (i_y_q),
        .i_m_ready (m_ready),
        .o_m_data  (m_data),
        .o_m_last  (m_last),
        .o_done    (w_drain_done)
    );

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Directed bench for sort_stream_adapter with a behavioural max-sort wrapper
// (two register stages, so i_y_q is ready by the third edge after o_chi moves).
module tb_sort_stream_adapter;

    localparam int M   = 8;
    localparam int N   = 8;
    localparam int W   = 4;
    localparam int LAT = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [N-1:0]        s_data = '0;
    logic                s_last = 1'b0;
    logic [M-1:0][N-1:0] o_chi;
    logic [W-1:0][N-1:0] i_y_q;
    logic [W-1:0][N-1:0] r_stage1;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [N-1:0]        m_data;
    logic                m_last;
    logic                o_busy;

    int checks = 0;
    int errors = 0;
    int bad_ready = 0;

    always #5 clk = ~clk;

    sort_stream_adapter #(.M(M), .N(N), .W(W), .LAT(LAT), .PAD('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .o_chi(o_chi), .i_y_q(i_y_q),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_busy(o_busy)
    );

    // Reference sorter: largest W lanes, largest first.
    function automatic logic [W-1:0][N-1:0] top_w(input logic [M-1:0][N-1:0] v);
        logic [N-1:0]        a [M];
        logic [N-1:0]        t;
        logic [W-1:0][N-1:0] r;
        for (int i = 0; i < M; i++) a[i] = v[i];
        for (int i = 0; i < M; i++)
            for (int j = i + 1; j < M; j++)
                if (a[j] > a[i]) begin t = a[i]; a[i] = a[j]; a[j] = t; end
        for (int k = 0; k < W; k++) r[k] = a[k];
        return r;
    endfunction

    always @(posedge clk) begin
        r_stage1 <= top_w(o_chi);
        i_y_q    <= r_stage1;
    end

    // s_ready must be the exact complement of o_busy outside reset.
    always @(negedge clk) begin
        if (rst_n && (s_ready === o_busy)) bad_ready++;
    end

    // Offer one element (called at a negedge), returns at the negedge after acceptance.
    task automatic send(input logic [7:0] d, input logic l);
        int g;
        g = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout got s_ready=0 for %0d cycles required 1", g);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Accept n output elements; waits = negedges spent before the first m_valid.
    task automatic collect(input int n, output logic [7:0] d[4], output logic lst[4],
                           output int waits);
        int g;
        for (int k = 0; k < 4; k++) begin d[k] = 8'hxx; lst[k] = 1'bx; end
        waits = -1;
        m_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            g = 0;
            while (!m_valid && g < 200) begin @(negedge clk); g++; end
            if (g >= 200) begin
                checks++; errors++;
                $display("FAIL collect_timeout got m_valid=0 required 1 at element %0d", k);
                break;
            end
            if (k == 0) waits = g;
            d[k] = m_data; lst[k] = m_last;
            @(negedge clk);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b required 0", o_busy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b required 0", m_valid); end
        checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL rst_m_last got %b required 0", m_last); end
        checks++; if (m_data !== 8'd0)  begin errors++; $display("FAIL rst_m_data got %0d required 0", m_data); end
        checks++; if (o_chi !== '0)     begin errors++; $display("FAIL rst_chi got %h required 0", o_chi); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b required 1", s_ready); end
        $display("reset: released, s_ready=%b o_busy=%b", s_ready, o_busy);
    endtask

    task automatic test_full_frame();
        logic [7:0]          vals [8] = '{5, 200, 17, 99, 3, 250, 64, 1};
        logic [7:0]          expd [4] = '{250, 200, 99, 64};
        logic [M-1:0][N-1:0] exp_chi;
        logic [7:0]          d [4];
        logic                lst [4];
        int                  waits;
        exp_chi = {8'd1, 8'd64, 8'd250, 8'd3, 8'd99, 8'd17, 8'd200, 8'd5};
        for (int i = 0; i < 8; i++) send(vals[i], i == 7);
        checks++; if (o_chi !== exp_chi) begin errors++; $display("FAIL full_chi got %h required %h", o_chi, exp_chi); end
        checks++; if (o_busy !== 1'b1)   begin errors++; $display("FAIL full_busy got %b required 1", o_busy); end
        collect(4, d, lst, waits);
        // m_valid seen after edge E+3, so the first output handshake is E+4.
        checks++; if (waits !== LAT) begin errors++; $display("FAIL full_latency got %0d required %0d", waits, LAT); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (d[k] !== expd[k])  begin errors++; $display("FAIL full_data[%0d] got %0d required %0d", k, d[k], expd[k]); end
            checks++; if (lst[k] !== (k == 3)) begin errors++; $display("FAIL full_last[%0d] got %b required %b", k, lst[k], k == 3); end
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b required 1", s_ready); end
        $display("full_frame: out %0d %0d %0d %0d wait %0d", d[0], d[1], d[2], d[3], waits);
    endtask

    task automatic test_short_frame();
        logic [7:0]          expd [4] = '{12, 9, 7, 0};
        logic [M-1:0][N-1:0] exp_chi;
        logic [7:0]          d [4];
        logic                lst [4];
        int                  waits;
        exp_chi = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd12, 8'd7, 8'd9};
        send(8'd9, 1'b0); send(8'd7, 1'b0); send(8'd12, 1'b1);
        checks++; if (o_chi !== exp_chi) begin errors++; $display("FAIL short_chi got %h required %h", o_chi, exp_chi); end
        collect(4, d, lst, waits);
        for (int k = 0; k < 4; k++) begin
            checks++; if (d[k] !== expd[k])  begin errors++; $display("FAIL short_data[%0d] got %0d required %0d", k, d[k], expd[k]); end
            checks++; if (lst[k] !== (k == 3)) begin errors++; $display("FAIL short_last[%0d] got %b required %b", k, lst[k], k == 3); end
        end
        $display("short_frame: out %0d %0d %0d %0d", d[0], d[1], d[2], d[3]);
    endtask

    task automatic test_split_frame();
        logic [7:0] vals [8] = '{30, 5, 77, 14, 90, 2, 61, 45};
        logic [7:0] exp1 [4] = '{90, 77, 61, 45};
        logic [7:0] exp2 [4] = '{99, 20, 8, 0};
        logic [7:0] d1 [4];
        logic [7:0] d2 [4];
        logic       l1 [4];
        logic       l2 [4];
        int         w1, w2;
        for (int i = 0; i < 8; i++) send(vals[i], 1'b0);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL split_ready_wait got %b required 0", s_ready); end
        fork
            begin send(8'd8, 1'b0); send(8'd99, 1'b0); send(8'd20, 1'b1); end
            begin collect(4, d1, l1, w1); collect(4, d2, l2, w2); end
        join
        for (int k = 0; k < 4; k++) begin
            checks++; if (d1[k] !== exp1[k]) begin errors++; $display("FAIL split_job1[%0d] got %0d required %0d", k, d1[k], exp1[k]); end
            checks++; if (d2[k] !== exp2[k]) begin errors++; $display("FAIL split_job2[%0d] got %0d required %0d", k, d2[k], exp2[k]); end
        end
        checks++; if (l1[3] !== 1'b1 || l2[3] !== 1'b1) begin errors++; $display("FAIL split_last got %b/%b required 1/1", l1[3], l2[3]); end
        $display("split_frame: job1 %0d %0d %0d %0d job2 %0d %0d %0d %0d",
                 d1[0], d1[1], d1[2], d1[3], d2[0], d2[1], d2[2], d2[3]);
    endtask

    task automatic test_backpressure();
        logic [7:0] expd [3] = '{40, 8, 4};
        logic [7:0] d [4];
        logic       lst [4];
        logic [7:0] first;
        int         waits, g;
        send(8'd4, 1'b0); send(8'd40, 1'b0); send(8'd8, 1'b0); send(8'd80, 1'b1);
        g = 0;
        while (!m_valid && g < 200) begin @(negedge clk); g++; end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b required 1", m_valid); end
        m_ready = 1'b1; first = m_data;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (first !== 8'd80) begin errors++; $display("FAIL bp_first got %0d required 80", first); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'd40 || m_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b d=%0d l=%b required v=1 d=40 l=0", c, m_valid, m_data, m_last);
            end
            @(negedge clk);
        end
        collect(3, d, lst, waits);
        for (int k = 0; k < 3; k++) begin
            checks++; if (d[k] !== expd[k])  begin errors++; $display("FAIL bp_data[%0d] got %0d required %0d", k, d[k], expd[k]); end
            checks++; if (lst[k] !== (k == 2)) begin errors++; $display("FAIL bp_last[%0d] got %b required %b", k, lst[k], k == 2); end
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_done got m_valid=%b required 0", m_valid); end
        $display("backpressure: out %0d %0d %0d %0d", first, d[0], d[1], d[2]);
    endtask

    task automatic test_reset_midway();
        logic [7:0] expd [4] = '{3, 2, 1, 0};
        logic [7:0] d [4];
        logic       lst [4];
        int         waits, g;
        // Reset while waiting on the sorter.
        send(8'd50, 1'b0); send(8'd60, 1'b1);
        rst_n = 1'b0; #1;
        checks++; if (o_busy !== 1'b0 || m_valid !== 1'b0 || o_chi !== '0) begin
            errors++; $display("FAIL rst_wait got busy=%b v=%b chi=%h required 0/0/0", o_busy, m_valid, o_chi);
        end
        @(negedge clk); rst_n = 1'b1;
        // Reset part-way through draining.
        send(8'd70, 1'b0); send(8'd80, 1'b1);
        g = 0;
        while (!m_valid && g < 200) begin @(negedge clk); g++; end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++; if (m_data !== 8'd70) begin errors++; $display("FAIL rst_pre_drain got %0d required 70", m_data); end
        rst_n = 1'b0; #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'd0 || m_last !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rst_drain got v=%b d=%0d l=%b busy=%b required 0/0/0/0", m_valid, m_data, m_last, o_busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_idle got v=%b rdy=%b required 0/1", m_valid, s_ready);
        end
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
        collect(4, d, lst, waits);
        for (int k = 0; k < 4; k++) begin
            checks++; if (d[k] !== expd[k])  begin errors++; $display("FAIL rst_after[%0d] got %0d required %0d", k, d[k], expd[k]); end
            checks++; if (lst[k] !== (k == 3)) begin errors++; $display("FAIL rst_after_last[%0d] got %b required %b", k, lst[k], k == 3); end
        end
        $display("reset_midway: out %0d %0d %0d %0d", d[0], d[1], d[2], d[3]);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [6] = '{11, 12, 13, 21, 22, 23};
        logic       lasts [6] = '{0, 0, 1, 0, 0, 1};
        logic [7:0] expd [8] = '{13, 12, 11, 0, 23, 22, 21, 0};
        logic [7:0] got [8];
        logic       gl [8];
        logic       rdy;
        int         idx, nout, busy;
        idx = 0; nout = 0; busy = 0;
        for (int k = 0; k < 8; k++) begin got[k] = 8'hxx; gl[k] = 1'bx; end
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = vals[0]; s_last = lasts[0];
        for (int c = 0; c < 40; c++) begin
            rdy = s_ready;
            if (m_valid && nout < 8) begin got[nout] = m_data; gl[nout] = m_last; nout++; end
            if (o_busy) busy++;
            @(negedge clk);
            if (rdy && idx < 6) begin
                idx++;
                if (idx < 6) begin s_data = vals[idx]; s_last = lasts[idx]; end
                else begin s_valid = 1'b0; s_last = 1'b0; end
            end
        end
        m_ready = 1'b0;
        checks++; if (nout !== 8) begin errors++; $display("FAIL b2b_count got %0d required 8", nout); end
        checks++; if (idx !== 6)  begin errors++; $display("FAIL b2b_accepted got %0d required 6", idx); end
        // Each frame is busy for LAT + W cycles.
        checks++; if (busy !== 2 * (LAT + W)) begin errors++; $display("FAIL b2b_busy got %0d required %0d", busy, 2 * (LAT + W)); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (got[k] !== expd[k]) begin errors++; $display("FAIL b2b_data[%0d] got %0d required %0d", k, got[k], expd[k]); end
            checks++; if (gl[k] !== (k % 4 == 3)) begin errors++; $display("FAIL b2b_last[%0d] got %b required %b", k, gl[k], k % 4 == 3); end
        end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL ready_vs_busy got %0d bad cycles required 0", bad_ready); end
        $display("back_to_back: %0d outputs, busy %0d cycles", nout, busy);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_split_frame();
        test_backpressure();
        test_reset_midway();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
